// File: rtl/scan_seq_3_6.sv
// Code sequencer for the 3-to-6 decoder select: steps a through 0..LAST at a
// programmable dwell rate (RUN) or one code per step request (IDLE).
module scan_seq_3_6 #(
    parameter int DIV       = 50000,
    parameter int DIV_WIDTH = 16,
    parameter int LAST      = 5,
    parameter int SCANS     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       step,
    output logic [2:0] a,
    output logic       busy,
    output logic       tick,
    output logic       wrap,
    output logic       done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST  = DIV_WIDTH'(DIV - 1);
    localparam logic [2:0]           LAST_C    = 3'(LAST);
    localparam logic [7:0]           SCAN_LAST = 8'((SCANS == 0) ? 0 : SCANS - 1);
    localparam bit                   COUNT_SCANS = (SCANS != 0);

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [7:0]           scan_cnt;
    logic [2:0]           adv_code;
    logic                 adv_wrap;

    function automatic logic [2:0] next_code(input logic [2:0] cur, input logic down);
        if (down)
            next_code = (cur == 3'd0) ? LAST_C : cur - 3'd1;
        else
            next_code = (cur == LAST_C) ? 3'd0 : cur + 3'd1;
    endfunction

    function automatic logic is_wrap(input logic [2:0] cur, input logic down);
        is_wrap = down ? (cur == 3'd0) : (cur == LAST_C);
    endfunction

    assign adv_code = next_code(a, dir);
    assign adv_wrap = is_wrap(a, dir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= 3'd0;
            busy     <= 1'b0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            scan_cnt <= 8'd0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // stop outranks start, which outranks step
                    if (!stop) begin
                        if (start) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            scan_cnt <= 8'd0;
                        end else if (step) begin
                            a    <= adv_code;
                            tick <= 1'b1;
                            wrap <= adv_wrap;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        scan_cnt <= 8'd0;
                    end else if (en) begin
                        if (cnt == DIV_LAST) begin
                            cnt  <= '0;
                            a    <= adv_code;
                            tick <= 1'b1;
                            wrap <= adv_wrap;
                            // only wraps taken while running count toward auto-stop
                            if (adv_wrap && COUNT_SCANS) begin
                                if (scan_cnt == SCAN_LAST) begin
                                    done     <= 1'b1;
                                    scan_cnt <= 8'd0;
                                    state    <= IDLE;
                                    busy     <= 1'b0;
                                end else begin
                                    scan_cnt <= scan_cnt + 8'd1;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq_3_6.sv
// Bench for scan_seq_3_6: a free-running instance (DIV=3) and an auto-stopping
// instance (DIV=1, SCANS=2) share stimulus and are tracked by a behavioural model.
module tb_scan_seq_3_6;

    localparam int L = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0, step = 1'b0;
    logic [2:0] a0, a1;
    logic busy0, tick0, wrap0, done0;
    logic busy1, tick1, wrap1, done1;

    int n_vec = 0;
    int n_err = 0;

    int p_div[2]   = '{3, 1};
    int p_scans[2] = '{0, 2};
    int m_a[2], m_run[2], m_cnt[2], m_scan[2], m_tick[2], m_wrap[2], m_done[2];

    always #5 clk = ~clk;

    scan_seq_3_6 #(.DIV(3), .DIV_WIDTH(16), .LAST(L), .SCANS(0)) dut_free (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .dir(dir), .step(step),
        .a(a0), .busy(busy0), .tick(tick0), .wrap(wrap0), .done(done0)
    );

    scan_seq_3_6 #(.DIV(1), .DIV_WIDTH(16), .LAST(L), .SCANS(2)) dut_auto (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .dir(dir), .step(step),
        .a(a1), .busy(busy1), .tick(tick1), .wrap(wrap1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_scan[i] = 0;
            m_tick[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
        end
    endtask

    // Behavioural rules: codes live on a ring of L+1 values; a wrap is leaving
    // the ring end in the travel direction; every SCANS-th running wrap stops.
    task automatic model_step(input int i);
        bit adv = 0;
        m_tick[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
        if (m_run[i] == 0) begin
            if (stop) ;
            else if (start) begin m_run[i] = 1; m_cnt[i] = 0; m_scan[i] = 0; end
            else if (step) adv = 1;
        end else begin
            if (stop) begin m_run[i] = 0; m_cnt[i] = 0; m_scan[i] = 0; end
            else if (en) begin
                m_cnt[i]++;
                if (m_cnt[i] == p_div[i]) begin m_cnt[i] = 0; adv = 1; end
            end
        end
        if (adv) begin
            m_tick[i] = 1;
            if (dir) begin
                m_wrap[i] = (m_a[i] == 0);
                m_a[i] = (m_a[i] + L) % (L + 1);
            end else begin
                m_wrap[i] = (m_a[i] == L);
                m_a[i] = (m_a[i] + 1) % (L + 1);
            end
            if (m_wrap[i] && m_run[i] && p_scans[i] != 0) begin
                m_scan[i]++;
                if (m_scan[i] == p_scans[i]) begin
                    m_done[i] = 1; m_scan[i] = 0; m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("free_a", a0, m_a[0]);       chk("free_busy", busy0, m_run[0]);
        chk("free_tick", tick0, m_tick[0]); chk("free_wrap", wrap0, m_wrap[0]);
        chk("free_done", done0, m_done[0]);
        chk("auto_a", a1, m_a[1]);       chk("auto_busy", busy1, m_run[1]);
        chk("auto_tick", tick1, m_tick[1]); chk("auto_wrap", wrap1, m_wrap[1]);
        chk("auto_done", done1, m_done[1]);
    endtask

    // Apply one cycle of inputs (set at negedge), advance the model, check.
    task automatic cyc(input logic i_en, input logic i_start, input logic i_stop,
                       input logic i_dir, input logic i_step);
        en = i_en; start = i_start; stop = i_stop; dir = i_dir; step = i_step;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int guard;
        int advances;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // first scan, up
        cyc(1, 1, 0, 0, 0);
        repeat (19) cyc(1, 0, 0, 0, 0);

        // down count, then flip back up
        guard = 0;
        while (!(m_run[0] && m_a[0] == 2 && m_cnt[0] == 0) && guard < 40) begin
            cyc(1, 0, 0, 0, 0); guard++;
        end
        chk("reach_a2", guard < 40, 1);
        repeat (12) cyc(1, 0, 0, 1, 0);
        repeat (6) cyc(1, 0, 0, 0, 0);

        // pause: nothing may move
        repeat (10) cyc(0, 0, 0, 0, 0);

        // stop on the terminal-count cycle
        guard = 0;
        while (m_cnt[0] != 2 && guard < 10) begin cyc(1, 0, 0, 0, 0); guard++; end
        chk("reach_tc", m_cnt[0], 2);
        cyc(1, 0, 1, 0, 0);
        chk("stop_tc_tick", tick0, 0);
        chk("stop_tc_busy", busy0, 0);

        // auto-stop on the DIV=1 instance: count advances until done
        cyc(0, 1, 1, 0, 0);                 // start+stop stays idle
        chk("start_stop_idle", busy1, 0);
        guard = 0;
        while (m_a[1] != 0 && guard < 10) begin cyc(0, 0, 0, 0, 1); guard++; end
        cyc(1, 1, 0, 0, 1);                 // start+step: run, no advance
        chk("start_step_tick", tick1, 0);
        advances = 0; guard = 0;
        while (!done1 && guard < 30) begin
            cyc(1, 0, 0, 0, 0); guard++;
            if (tick1) advances++;
        end
        chk("auto_advances", advances, 12);
        chk("auto_done_wrap", wrap1, 1);
        chk("auto_done_busy", busy1, 0);
        cyc(0, 0, 1, 0, 0);

        // IDLE stepping from a=5
        guard = 0;
        while (m_a[0] != L && guard < 10) begin cyc(0, 0, 0, 0, 1); guard++; end
        cyc(0, 0, 0, 0, 1);
        chk("step_wrap_a", a0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("step_a1", a0, 1);

        // async reset mid-run at a=3, cnt=1
        cyc(1, 1, 0, 0, 0);
        guard = 0;
        while (!(m_a[0] == 3 && m_cnt[0] == 1) && guard < 60) begin
            cyc(1, 0, 0, 0, 0); guard++;
        end
        chk("reach_a3", guard < 60, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_a", a0, 0);
        chk("areset_busy", busy0, 0);
        chk("areset_auto_a", a1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(1, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(7) != 0), ($urandom_range(15) == 0),
                ($urandom_range(31) == 0), $urandom_range(1), ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
